// File: rtl/alu_op_decoder.sv
// alu_op_decoder: MIPS instruction decode stage feeding the ID/EX register.
// Decodes the fetched instruction into the internal ALU function code,
// operand select, immediate, register indices and write/memory flags, and
// registers them with one cycle of latency behind a valid/ready handshake.
// A PC redirect (d_i_flush) empties the ID/EX register and consumes any
// instruction presented in the same cycle.
// Optional feature: define LOAD_USE_STALL_EN to insert exactly one bubble
// between a load and a dependent consumer. Without it, hazard is tied low
// and scheduling around load delay is left to the compiler.
// PC_WIDTH / IMM_WIDTH defaults match the project-wide header values.
`timescale 1ns/1ps

module alu_op_decoder #(
  parameter int PC_WIDTH   = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int INSN_WIDTH = 32
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic [INSN_WIDTH-1:0] d_i_insn,
  input  logic [PC_WIDTH-1:0]   d_i_pc,
  input  logic                  d_i_valid,
  output logic                  d_o_ready,
  input  logic                  d_i_ex_ready,
  input  logic                  d_i_flush,
  output logic                  d_o_valid,
  output logic [4:0]            d_o_funct,
  output logic                  d_o_alu_src,
  output logic [IMM_WIDTH-1:0]  d_o_imm,
  output logic [4:0]            d_o_rs_addr,
  output logic [4:0]            d_o_rt_addr,
  output logic [4:0]            d_o_rd_addr,
  output logic                  d_o_reg_write,
  output logic                  d_o_mem_read,
  output logic                  d_o_mem_write,
  output logic [PC_WIDTH-1:0]   d_o_pc,
  output logic                  d_o_illegal
);

  // Internal ALU operation encoding consumed by the EX stage
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NEQ  = 5'd11;
  localparam logic [4:0] ALU_ADDU = 5'd14;
  localparam logic [4:0] ALU_SUBU = 5'd17;
  localparam logic [4:0] ALU_LUI  = 5'd18;
  localparam logic [4:0] ALU_JR   = 5'd19;
  localparam logic [4:0] ALU_ILL  = 5'd31;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function fields
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Shift amount widened to the immediate bus, upper bits zero
  function automatic logic [IMM_WIDTH-1:0] shamt_imm(input logic [4:0] shamt);
    shamt_imm = IMM_WIDTH'(shamt);
  endfunction

  // 16-bit instruction immediate placed on the immediate bus unmodified;
  // the ALU does its own extension
  function automatic logic [IMM_WIDTH-1:0] insn_imm(input logic [15:0] imm16);
    insn_imm = IMM_WIDTH'(imm16);
  endfunction

  // Instruction fields
  logic [5:0] op_p0;
  logic [5:0] fn_p0;
  logic [4:0] rs_f_p0;
  logic [4:0] rt_f_p0;
  logic [4:0] rd_f_p0;
  logic [4:0] sh_f_p0;
  logic [15:0] imm_f_p0;

  assign op_p0    = d_i_insn[31:26];
  assign rs_f_p0  = d_i_insn[25:21];
  assign rt_f_p0  = d_i_insn[20:16];
  assign rd_f_p0  = d_i_insn[15:11];
  assign sh_f_p0  = d_i_insn[10:6];
  assign fn_p0    = d_i_insn[5:0];
  assign imm_f_p0 = d_i_insn[15:0];

  // Decoded (combinational) fields
  logic [4:0]           funct_p0;
  logic                 alu_src_p0;
  logic [IMM_WIDTH-1:0] imm_p0;
  logic [4:0]           rs_addr_p0;
  logic [4:0]           rt_addr_p0;
  logic [4:0]           rd_addr_p0;
  logic                 wr_raw_p0;
  logic                 reg_write_p0;
  logic                 mem_read_p0;
  logic                 mem_write_p0;
  logic                 illegal_p0;
  logic                 reads_rt_p0;

  // ID/EX register contents
  logic                 vld_p1;
  logic [4:0]           funct_p1;
  logic                 alu_src_p1;
  logic [IMM_WIDTH-1:0] imm_p1;
  logic [4:0]           rs_addr_p1;
  logic [4:0]           rt_addr_p1;
  logic [4:0]           rd_addr_p1;
  logic                 reg_write_p1;
  logic                 mem_read_p1;
  logic                 mem_write_p1;
  logic                 illegal_p1;
  logic [PC_WIDTH-1:0]  pc_p1;

  logic advance;
  logic hazard;

  // Instruction decode: default is illegal, each legal pattern overrides
  always_comb begin
    funct_p0     = ALU_ILL;
    alu_src_p0   = 1'b0;
    imm_p0       = '0;
    rs_addr_p0   = rs_f_p0;
    rt_addr_p0   = rt_f_p0;
    rd_addr_p0   = rd_f_p0;
    wr_raw_p0    = 1'b0;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    illegal_p0   = 1'b1;
    reads_rt_p0  = 1'b0;
    unique case (op_p0)
      OP_RTYPE: begin
        unique case (fn_p0)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
            illegal_p0  = 1'b0;
            wr_raw_p0   = 1'b1;
            reads_rt_p0 = 1'b1;
            unique case (fn_p0)
              FN_ADD:  funct_p0 = ALU_ADD;
              FN_ADDU: funct_p0 = ALU_ADDU;
              FN_SUB:  funct_p0 = ALU_SUB;
              FN_SUBU: funct_p0 = ALU_SUBU;
              FN_AND:  funct_p0 = ALU_AND;
              FN_OR:   funct_p0 = ALU_OR;
              FN_NOR:  funct_p0 = ALU_NOR;
              FN_SLT:  funct_p0 = ALU_SLT;
              default: funct_p0 = ALU_SLTU;
            endcase
          end
          // Constant shifts: the shifted register travels on the rs port,
          // the shift amount on the immediate
          FN_SLL, FN_SRL, FN_SRA: begin
            illegal_p0 = 1'b0;
            wr_raw_p0  = 1'b1;
            alu_src_p0 = 1'b1;
            rs_addr_p0 = rt_f_p0;
            rt_addr_p0 = 5'd0;
            imm_p0     = shamt_imm(sh_f_p0);
            funct_p0   = (fn_p0 == FN_SLL) ? ALU_SLL :
                         (fn_p0 == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          // Variable shifts: operands swapped so the value is on rs and the
          // amount on rt, matching the constant-shift operand order
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            illegal_p0  = 1'b0;
            wr_raw_p0   = 1'b1;
            reads_rt_p0 = 1'b1;
            rs_addr_p0  = rt_f_p0;
            rt_addr_p0  = rs_f_p0;
            funct_p0    = (fn_p0 == FN_SLLV) ? ALU_SLL :
                          (fn_p0 == FN_SRLV) ? ALU_SRL : ALU_SRA;
          end
          FN_JR: begin
            illegal_p0 = 1'b0;
            funct_p0   = ALU_JR;
            rd_addr_p0 = 5'd0;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
        illegal_p0 = 1'b0;
        wr_raw_p0  = 1'b1;
        alu_src_p0 = 1'b1;
        imm_p0     = insn_imm(imm_f_p0);
        rd_addr_p0 = rt_f_p0;
        unique case (op_p0)
          OP_ADDI:  funct_p0 = ALU_ADD;
          OP_ADDIU: funct_p0 = ALU_ADDU;
          OP_SLTI:  funct_p0 = ALU_SLT;
          OP_SLTIU: funct_p0 = ALU_SLTU;
          default:  funct_p0 = ALU_LUI;
        endcase
      end
      OP_LW: begin
        illegal_p0  = 1'b0;
        funct_p0    = ALU_ADD;
        wr_raw_p0   = 1'b1;
        mem_read_p0 = 1'b1;
        alu_src_p0  = 1'b1;
        imm_p0      = insn_imm(imm_f_p0);
        rd_addr_p0  = rt_f_p0;
      end
      OP_SW: begin
        illegal_p0   = 1'b0;
        funct_p0     = ALU_ADD;
        mem_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        reads_rt_p0  = 1'b1;
        imm_p0       = insn_imm(imm_f_p0);
        rd_addr_p0   = rt_f_p0;
      end
      OP_BEQ, OP_BNE: begin
        illegal_p0  = 1'b0;
        reads_rt_p0 = 1'b1;
        rd_addr_p0  = 5'd0;
        funct_p0    = (op_p0 == OP_BEQ) ? ALU_EQ : ALU_NEQ;
      end
      default: ;
    endcase
  end

  // Writes to $0 are architecturally discarded
  assign reg_write_p0 = wr_raw_p0 & (rd_addr_p0 != 5'd0);

`ifdef LOAD_USE_STALL_EN
  // Load-use dependency between the held load and the presented instruction
  assign hazard = d_i_valid & vld_p1 & mem_read_p1 & (rd_addr_p1 != 5'd0) &
                  ((rd_addr_p1 == rs_addr_p0) |
                   ((rd_addr_p1 == rt_addr_p0) & reads_rt_p0));
`else
  assign hazard = 1'b0;
  logic unused_reads_rt;
  assign unused_reads_rt = reads_rt_p0;
`endif

  // A flush always consumes the presented instruction so IF can redirect
  assign advance   = d_i_ex_ready | ~vld_p1;
  assign d_o_ready = d_i_flush | (advance & ~hazard);

  // ID/EX register: reset, then flush, then advance with bubble on hazard
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      vld_p1       <= 1'b0;
      funct_p1     <= '0;
      alu_src_p1   <= 1'b0;
      imm_p1       <= '0;
      rs_addr_p1   <= '0;
      rt_addr_p1   <= '0;
      rd_addr_p1   <= '0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
      pc_p1        <= '0;
    end else if (d_i_flush) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      illegal_p1   <= 1'b0;
    end else if (advance) begin
      if (hazard || !d_i_valid) begin
        vld_p1       <= 1'b0;
        reg_write_p1 <= 1'b0;
        mem_read_p1  <= 1'b0;
        mem_write_p1 <= 1'b0;
        illegal_p1   <= 1'b0;
      end else begin
        vld_p1       <= 1'b1;
        funct_p1     <= funct_p0;
        alu_src_p1   <= alu_src_p0;
        imm_p1       <= imm_p0;
        rs_addr_p1   <= rs_addr_p0;
        rt_addr_p1   <= rt_addr_p0;
        rd_addr_p1   <= rd_addr_p0;
        reg_write_p1 <= reg_write_p0;
        mem_read_p1  <= mem_read_p0;
        mem_write_p1 <= mem_write_p0;
        illegal_p1   <= illegal_p0;
        pc_p1        <= d_i_pc;
      end
    end
  end

  assign d_o_valid     = vld_p1;
  assign d_o_funct     = funct_p1;
  assign d_o_alu_src   = alu_src_p1;
  assign d_o_imm       = imm_p1;
  assign d_o_rs_addr   = rs_addr_p1;
  assign d_o_rt_addr   = rt_addr_p1;
  assign d_o_rd_addr   = rd_addr_p1;
  assign d_o_reg_write = reg_write_p1;
  assign d_o_mem_read  = mem_read_p1;
  assign d_o_mem_write = mem_write_p1;
  assign d_o_pc        = pc_p1;
  assign d_o_illegal   = illegal_p1;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Testbench for alu_op_decoder: directed instruction sequence with a
// scoreboard of expected ID/EX contents, one entry per clock.
`timescale 1ns/1ps

module tb_alu_op_decoder;

  localparam int M_F   = 1;
  localparam int M_SRC = 2;
  localparam int M_IMM = 4;
  localparam int M_RS  = 8;
  localparam int M_RT  = 16;
  localparam int M_RD  = 32;
  localparam int M_PC  = 64;
  localparam int M_ALL = 127;

  typedef struct {
    logic        v;
    logic [4:0]  f;
    logic        src;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    logic [31:0] pc;
    int          mask;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        in_valid;
  logic        ready;
  logic        ex_ready;
  logic        flush;
  logic        o_valid;
  logic [4:0]  o_funct;
  logic        o_alu_src;
  logic [15:0] o_imm;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic        o_rw;
  logic        o_mr;
  logic        o_mw;
  logic [31:0] o_pc;
  logic        o_ill;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  alu_op_decoder dut (
    .d_clk         (clk),
    .d_rst         (rst),
    .d_i_insn      (insn),
    .d_i_pc        (pc),
    .d_i_valid     (in_valid),
    .d_o_ready     (ready),
    .d_i_ex_ready  (ex_ready),
    .d_i_flush     (flush),
    .d_o_valid     (o_valid),
    .d_o_funct     (o_funct),
    .d_o_alu_src   (o_alu_src),
    .d_o_imm       (o_imm),
    .d_o_rs_addr   (o_rs),
    .d_o_rt_addr   (o_rt),
    .d_o_rd_addr   (o_rd),
    .d_o_reg_write (o_rw),
    .d_o_mem_read  (o_mr),
    .d_o_mem_write (o_mw),
    .d_o_pc        (o_pc),
    .d_o_illegal   (o_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic v, input logic [4:0] f, input logic src,
                      input logic [15:0] imm, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw,
                      input logic ill, input logic [31:0] p, input int mask);
    exp_t e;
    e.v = v; e.f = f; e.src = src; e.imm = imm; e.rs = rs; e.rt = rt;
    e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill; e.pc = p;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic push_idle();
    push(1'b0, 5'd0, 1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  // Compare the held ID/EX contents against the oldest scoreboard entry
  task automatic check_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"},   32'(o_valid), 32'(e.v));
    chk({tag, ".rw"},      32'(o_rw),    32'(e.rw));
    chk({tag, ".mr"},      32'(o_mr),    32'(e.mr));
    chk({tag, ".mw"},      32'(o_mw),    32'(e.mw));
    chk({tag, ".illegal"}, 32'(o_ill),   32'(e.ill));
    if ((e.mask & M_F)   != 0) chk({tag, ".funct"},   32'(o_funct),   32'(e.f));
    if ((e.mask & M_SRC) != 0) chk({tag, ".alu_src"}, 32'(o_alu_src), 32'(e.src));
    if ((e.mask & M_IMM) != 0) chk({tag, ".imm"},     32'(o_imm),     32'(e.imm));
    if ((e.mask & M_RS)  != 0) chk({tag, ".rs"},      32'(o_rs),      32'(e.rs));
    if ((e.mask & M_RT)  != 0) chk({tag, ".rt"},      32'(o_rt),      32'(e.rt));
    if ((e.mask & M_RD)  != 0) chk({tag, ".rd"},      32'(o_rd),      32'(e.rd));
    if ((e.mask & M_PC)  != 0) chk({tag, ".pc"},      o_pc,           e.pc);
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    insn     = i;
    pc       = p;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; insn = '0; pc = '0; in_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    push(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, M_ALL);
    check_head("reset");
    rst = 1'b0;

    // add $3,$1,$2
    apply(32'h00221820, 32'h100); #1; chk("add.ready", 32'(ready), 32'd1);
    push(1, 5'd0, 0, 16'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 32'h100, M_F|M_SRC|M_RS|M_RT|M_RD|M_PC);
    tick(); check_head("add");
    // sll $4,$2,3
    apply(32'h000220C0, 32'h104);
    push(1, 5'd7, 1, 16'h0003, 5'd2, 5'd0, 5'd4, 1, 0, 0, 0, 32'h104, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("sll");
    // lui $7,0x1234
    apply(32'h3C071234, 32'h108);
    push(1, 5'd18, 1, 16'h1234, 5'd0, 5'd0, 5'd7, 1, 0, 0, 0, 32'h108, M_F|M_SRC|M_IMM|M_RD|M_PC);
    tick(); check_head("lui");
    // beq $1,$2
    apply(32'h10220008, 32'h10C);
    push(1, 5'd10, 0, 16'h0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 32'h10C, M_F|M_SRC|M_RS|M_RT|M_PC);
    tick(); check_head("beq");
    // sw $5,8($2)
    apply(32'hAC450008, 32'h110);
    push(1, 5'd0, 1, 16'h0008, 5'd2, 5'd5, 5'd0, 0, 0, 1, 0, 32'h110, M_F|M_SRC|M_IMM|M_RS|M_RT|M_PC);
    tick(); check_head("sw");
    // addiu $3,$0,-1
    apply(32'h2403FFFF, 32'h114);
    push(1, 5'd14, 1, 16'hFFFF, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 32'h114, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("addiu");
    // sltu $3,$1,$2
    apply(32'h0022182B, 32'h118);
    push(1, 5'd6, 0, 16'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 32'h118, M_F|M_SRC|M_RS|M_RT|M_RD|M_PC);
    tick(); check_head("sltu");
    // sllv $6,$2,$5: value register on rs, amount register on rt
    apply(32'h00A23004, 32'h11C);
    push(1, 5'd7, 0, 16'h0, 5'd2, 5'd5, 5'd6, 1, 0, 0, 0, 32'h11C, M_F|M_SRC|M_RS|M_RT|M_RD|M_PC);
    tick(); check_head("sllv");
    // jr $31
    apply(32'h03E00008, 32'h120);
    push(1, 5'd19, 0, 16'h0, 5'd31, 5'd0, 5'd0, 0, 0, 0, 0, 32'h120, M_F|M_RS|M_PC);
    tick(); check_head("jr");
    // andi is not decodable here
    apply(32'h30A5FFFF, 32'h124);
    push(1, 5'd31, 0, 16'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h124, M_F|M_PC);
    tick(); check_head("andi");
    // lw $0,4($1): write to $0 suppressed
    apply(32'h8C200004, 32'h128);
    push(1, 5'd0, 1, 16'h0004, 5'd1, 5'd0, 5'd0, 0, 1, 0, 0, 32'h128, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("lw_r0");

    // Load-use pair: lw $5 then add $6,$5,$5
    apply(32'h8C250004, 32'h12C); #1; chk("lu_lw.ready", 32'(ready), 32'd1);
    push(1, 5'd0, 1, 16'h0004, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 32'h12C, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("lu_lw");
    apply(32'h00A53020, 32'h130); #1;
`ifdef LOAD_USE_STALL_EN
    chk("lu_stall.ready", 32'(ready), 32'd0);
    push_idle();
    tick(); check_head("lu_bubble");
    #1; chk("lu_resume.ready", 32'(ready), 32'd1);
`else
    chk("lu_nostall.ready", 32'(ready), 32'd1);
`endif
    push(1, 5'd0, 0, 16'h0, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 32'h130, M_F|M_SRC|M_RS|M_RT|M_RD|M_PC);
    tick(); check_head("lu_add");

    // Flush while a load is held and a dependent instruction is presented
    apply(32'h8C250004, 32'h134);
    push(1, 5'd0, 1, 16'h0004, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 32'h134, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("fl_lw");
    apply(32'h00A53020, 32'h138); flush = 1'b1; #1;
    chk("fl.ready", 32'(ready), 32'd1);
    push_idle();
    tick(); check_head("fl_empty");
    flush = 1'b0; in_valid = 1'b0;
    push_idle();
    tick(); check_head("fl_dropped");

    // Illegal opcode held while EX back-pressures for three cycles
    apply(32'hFC000000, 32'h140);
    push(1, 5'd31, 0, 16'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h140, M_F|M_PC);
    tick(); check_head("ill");
    ex_ready = 1'b0;
    apply(32'h00221820, 32'h144);
    for (int k = 0; k < 3; k++) begin
      #1; chk("bp.ready", 32'(ready), 32'd0);
      push(1, 5'd31, 0, 16'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h140, M_F|M_PC);
      tick(); check_head("bp_hold");
    end
    ex_ready = 1'b1; #1;
    chk("bp_release.ready", 32'(ready), 32'd1);
    push(1, 5'd0, 0, 16'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 32'h144, M_F|M_SRC|M_RS|M_RT|M_RD|M_PC);
    tick(); check_head("bp_add");
    in_valid = 1'b0;
    push_idle();
    tick(); check_head("bp_idle");

    // Reset arriving during a load-use stall; nothing is replayed
    apply(32'h8C250004, 32'h150);
    push(1, 5'd0, 1, 16'h0004, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 32'h150, M_F|M_SRC|M_IMM|M_RS|M_RD|M_PC);
    tick(); check_head("rs_lw");
    apply(32'h00A53020, 32'h154); rst = 1'b1;
    push(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, M_ALL);
    tick(); check_head("rs_reset");
    rst = 1'b0; in_valid = 1'b0;
    push_idle();
    tick(); check_head("rs_no_replay");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Decode stage that produces the internal ALU operation encoding consumed by the EX-stage ALU.
- Takes a fetched 32-bit MIPS instruction and its PC over a valid/ready handshake.
- Registers the ALU function code, operand-select, immediate, register addresses and control flags into the ID/EX register.
- Handles flush on PC change and single-bubble load-use stall.

Parameters:
- PC_WIDTH, 32, PC width; equals `PC_WIDTH from header.vh.
- IMM_WIDTH, 16, immediate width; equals `IMM_WIDTH from header.vh.
- INSN_WIDTH, 32, instruction width.

Ports:
- d_clk  input  1  clock, rising edge.
- d_rst  input  1  synchronous active-high reset.
- d_i_insn  input  INSN_WIDTH  instruction from IF.
- d_i_pc  input  PC_WIDTH  PC of d_i_insn.
- d_i_valid  input  1  d_i_insn/d_i_pc valid.
- d_o_ready  output  1  decoder accepts input this cycle (combinational).
- d_i_ex_ready  input  1  EX accepts the ID/EX register contents.
- d_i_flush  input  1  PC redirect (EX change_pc/taken branch).
- d_o_valid  output  1  ID/EX register holds a real instruction.
- d_o_funct  output  5  ALU function code.
- d_o_alu_src  output  1  1 = second operand is the immediate.
- d_o_imm  output  IMM_WIDTH  immediate to ALU.
- d_o_rs_addr, d_o_rt_addr  output  5 each  source register indices.
- d_o_rd_addr  output  5  destination index.
- d_o_reg_write, d_o_mem_read, d_o_mem_write  output  1 each  control flags.
- d_o_pc  output  PC_WIDTH  PC of the held instruction.
- d_o_illegal  output  1  held instruction not decodable.

Behaviour:
- Reset: all registered outputs 0, d_o_funct=0, d_o_valid=0.
- Latency: one cycle, input transfer -> registered outputs.
- Transfer rules:
  - Input transfer when d_i_valid & d_o_ready.
  - Register advances when d_i_ex_ready | ~d_o_valid.
  - d_o_ready = (d_i_ex_ready | ~d_o_valid) & ~hazard.
- ALU codes:
  - add=0, sub=1, and=2, or=3, nor=4, slt=5, sltu=6, sll=7, srl=8, sra=9, eq=10, neq=11, addu=14, subu=17, lui=18, jr=19, illegal=31.
- R-type (op 0):
  - funct 0x20/21/22/23/24/25/27/2A/2B -> add/addu/sub/subu/and/or/nor/slt/sltu; alu_src=0; rd=insn[15:11].
  - sll/srl/sra (0x00/02/03): rs_addr=insn[20:16], imm={11'b0,shamt}, alu_src=1.
  - sllv/srlv/srav (0x04/06/07): rs_addr=insn[20:16], rt_addr=insn[25:21], alu_src=0.
  - jr (0x08): funct 19, reg_write=0.
- I-type, alu_src=1, imm=insn[15:0], rd=insn[20:16]:
  - addi 0x08 -> 0; addiu 0x09 -> 14; slti 0x0A -> 5; sltiu 0x0B -> 6; lui 0x0F -> 18.
  - lw 0x23 -> 0, mem_read=1.
  - sw 0x2B -> 0, mem_write=1, reg_write=0.
- Branches: beq 0x04 -> 10, bne 0x05 -> 11; alu_src=0, reg_write=0.
- Every other opcode/funct, including andi/ori (the ALU sign-extends): d_o_illegal=1, funct=31, all write flags 0, valid still 1.
- reg_write forced 0 when rd_addr=0.
- Flush (highest priority after reset): next edge d_o_valid=0. Any input presented that cycle is consumed (d_o_ready=1) and discarded.
- Simultaneous flush and hazard: flush wins.
- Reset mid-stall: clears the bubble state; nothing is replayed.

Optional Feature:
- LOAD_USE_STALL_EN defined:
  - hazard = d_i_valid & d_o_valid & d_o_mem_read & d_o_rd_addr!=0 & (d_o_rd_addr==decoded rs_addr | (d_o_rd_addr==decoded rt_addr & instruction reads rt)).
  - If hazard and d_i_ex_ready: register loads a bubble (valid=0, flags 0) and input is held. Exactly one bubble per load-use pair.
- Not defined: hazard tied 0; scheduling is the compiler's responsibility.

Test Plan:
- 0x00221820 (add $3,$1,$2) -> next cycle valid=1, funct=0, alu_src=0, rs=1, rt=2, rd=3, reg_write=1.
- 0x000220C0 (sll $4,$2,3) -> funct=7, rs_addr=2, alu_src=1, imm=0x0003, rd=4.
- 0x3C071234 (lui $7) -> funct=18, imm=0x1234, rd=7. Then 0x10220008 (beq) -> funct=10, alu_src=0, reg_write=0.
- LOAD_USE_STALL_EN: 0x8C250004 (lw $5) then 0x00A53020 (add $6,$5,$5), EX always ready -> lw, bubble (valid=0), add. d_o_ready=0 exactly one cycle.
- d_i_flush=1 while lw held and next insn valid -> next cycle valid=0, d_o_ready=1 during flush, dropped insn never appears.
- 0xFC000000 -> illegal=1, funct=31, reg_write=0. d_i_ex_ready=0 for 3 cycles -> outputs stable, d_o_ready=0.
